// File: rtl/jtag_debug_pkg.sv
// Shared types and defaults for the JTAG debug system-clock bridge.
package jtag_debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } state_t;

    localparam int DEF_SR_WIDTH    = 38;
    localparam int DEF_IR_WIDTH    = 2;
    localparam int DEF_ACTION_BIT  = 37;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_REQUIRE_ACK = 1;
    localparam int DEF_ACK_TIMEOUT = 255;

    // Wide enough to hold the timeout value itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/jtag_debug_toggle_sync.sv
// Brings a TCK-domain toggle into clk and turns each transition into a one-cycle event.
module jtag_debug_toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic toggle,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            evt    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], toggle};
            prev_q <= sync_q[SYNC_STAGES-1];
            evt    <= sync_q[SYNC_STAGES-1] ^ prev_q;
        end
    end

endmodule

// File: rtl/jtag_debug_sysclk_bridge.sv
// System-clock side of the debug JTAG path: captures update-DR snapshots and issues
// one-hot action/no-action pulses, with optional acknowledge, timeout and overrun flags.
module jtag_debug_sysclk_bridge
    import jtag_debug_pkg::*;
#(
    parameter int SR_WIDTH    = DEF_SR_WIDTH,
    parameter int IR_WIDTH    = DEF_IR_WIDTH,
    parameter int ACTION_BIT  = DEF_ACTION_BIT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int REQUIRE_ACK = DEF_REQUIRE_ACK,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    localparam int NUM_CMD    = 2 ** IR_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SR_WIDTH-1:0] sr_in,
    input  logic [IR_WIDTH-1:0] ir_in,
    input  logic                udr_toggle,
    input  logic                uir_toggle,
    output logic [SR_WIDTH-1:0] jdo,
    output logic [IR_WIDTH-1:0] cmd_ir,
    output logic [NUM_CMD-1:0]  take_action,
    output logic [NUM_CMD-1:0]  take_no_action,
    input  logic                cmd_ack,
    output logic                busy,
    output logic                overrun_err,
    output logic                timeout_err,
    input  logic                err_clr
);

    localparam int CNT_W = cnt_width(ACK_TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             udr_evt;
    logic             uir_evt;
    logic             capture;
    logic             set_timeout;
    logic             set_overrun;

    jtag_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk    (clk),
        .reset  (reset),
        .toggle (udr_toggle),
        .evt    (udr_evt)
    );

    jtag_debug_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk    (clk),
        .reset  (reset),
        .toggle (uir_toggle),
        .evt    (uir_evt)
    );

    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        set_timeout    = 1'b0;
        take_action    = '0;
        take_no_action = '0;
        case (state_q)
            ST_IDLE: begin
                if (udr_evt) begin
                    state_d = ST_CAPTURE;
                    capture = 1'b1;
                end
            end
            ST_CAPTURE: state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (jdo[ACTION_BIT]) take_action[cmd_ir]    = 1'b1;
                else                 take_no_action[cmd_ir] = 1'b1;
                // An IR update during the pulse lets it finish but skips the ack wait.
                state_d = (REQUIRE_ACK != 0 && !uir_evt) ? ST_WAIT_ACK : ST_IDLE;
            end
            ST_WAIT_ACK: begin
                // Ack beats a simultaneous timeout; an IR update aborts silently.
                if (cmd_ack || uir_evt) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_d     = ST_IDLE;
                    set_timeout = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign set_overrun = udr_evt && (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            jdo         <= '0;
            cmd_ir      <= '0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q != ST_WAIT_ACK) cnt_q <= '0;
            else                        cnt_q <= cnt_q + 1'b1;
            if (capture) begin
                jdo    <= sr_in;
                cmd_ir <= ir_in;
            end
            if (set_overrun)  overrun_err <= 1'b1;
            else if (err_clr) overrun_err <= 1'b0;
            if (set_timeout)  timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge.sv
// Self-checking bench: dut_a waits for ack with a short timeout, dut_b runs without ack.
module tb_jtag_debug_sysclk_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] sr_in = '0;
    logic [1:0]  ir_in = '0;
    logic        udr_toggle = 1'b0;
    logic        uir_toggle = 1'b0;
    logic        cmd_ack = 1'b0;
    logic        err_clr = 1'b0;

    logic [37:0] a_jdo, b_jdo;
    logic [1:0]  a_cmd_ir, b_cmd_ir;
    logic [3:0]  a_act, a_nact, b_act, b_nact;
    logic        a_busy, b_busy, a_ovr, b_ovr, a_tmo, b_tmo;

    int checks = 0;
    int failures = 0;
    logic [45:0] exp_q[$];

    always #5 clk = ~clk;

    jtag_debug_sysclk_bridge #(.ACK_TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset), .sr_in(sr_in), .ir_in(ir_in),
        .udr_toggle(udr_toggle), .uir_toggle(uir_toggle),
        .jdo(a_jdo), .cmd_ir(a_cmd_ir), .take_action(a_act), .take_no_action(a_nact),
        .cmd_ack(cmd_ack), .busy(a_busy), .overrun_err(a_ovr), .timeout_err(a_tmo),
        .err_clr(err_clr)
    );

    jtag_debug_sysclk_bridge #(.REQUIRE_ACK(0)) dut_b (
        .clk(clk), .reset(reset), .sr_in(sr_in), .ir_in(ir_in),
        .udr_toggle(udr_toggle), .uir_toggle(uir_toggle),
        .jdo(b_jdo), .cmd_ir(b_cmd_ir), .take_action(b_act), .take_no_action(b_nact),
        .cmd_ack(cmd_ack), .busy(b_busy), .overrun_err(b_ovr), .timeout_err(b_tmo),
        .err_clr(err_clr)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pulse_model(input logic [37:0] d, input logic [1:0] ir);
        logic [3:0] oh;
        oh = 4'b0001 << ir;
        return d[37] ? {oh, 4'b0000} : {4'b0000, oh};
    endfunction

    // Drives one update-DR and follows it to the pulse; dut_a is left in WAIT_ACK.
    task automatic run_cmd(input logic [37:0] d, input logic [1:0] ir, input bit with_uir);
        logic [7:0]  exp_vec;
        logic [45:0] exp;
        int          b_busy_n;
        b_busy_n = 0;
        exp_vec = pulse_model(d, ir);
        sr_in = d;
        ir_in = ir;
        udr_toggle = ~udr_toggle;
        if (with_uir) uir_toggle = ~uir_toggle;
        exp_q.push_back({exp_vec, d});
        for (int k = 0; k < 6; k++) begin
            tick();
            if (b_busy) b_busy_n++;
            checks++;
            if ({a_act, a_nact} !== ((k == 4) ? exp_vec : 8'h00)) begin
                failures++;
                $display("FAIL a_pulse edge=%0d got=%h exp=%h", k, {a_act, a_nact}, (k == 4) ? exp_vec : 8'h00);
            end
            checks++;
            if ({b_act, b_nact} !== ((k == 4) ? exp_vec : 8'h00)) begin
                failures++;
                $display("FAIL b_pulse edge=%0d got=%h exp=%h", k, {b_act, b_nact}, (k == 4) ? exp_vec : 8'h00);
            end
            if ({a_act, a_nact} != 8'h00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got=%h exp=none", {a_act, a_nact, a_jdo});
                end else begin
                    exp = exp_q.pop_front();
                    if ({a_act, a_nact, a_jdo} !== exp) begin
                        failures++;
                        $display("FAIL sb_pulse got=%h exp=%h", {a_act, a_nact, a_jdo}, exp);
                    end
                end
            end
        end
        checks++;
        if (b_busy_n != 2) begin
            failures++;
            $display("FAIL b_busy_cycles got=%0d exp=2", b_busy_n);
        end
        checks++;
        if (a_cmd_ir !== ir) begin
            failures++;
            $display("FAIL a_cmd_ir got=%0d exp=%0d", a_cmd_ir, ir);
        end
        checks++;
        if (a_busy !== 1'b1) begin
            failures++;
            $display("FAIL a_busy_wait got=%b exp=1", a_busy);
        end
    endtask

    task automatic ack_once();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL a_busy_after_ack got=%b exp=0", a_busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++;
        if ({a_jdo, a_cmd_ir, a_act, a_nact, a_busy, a_ovr, a_tmo} !== 49'h0) begin
            failures++;
            $display("FAIL reset_a got=%h exp=0", {a_jdo, a_cmd_ir, a_act, a_nact, a_busy, a_ovr, a_tmo});
        end
        checks++;
        if ({b_jdo, b_cmd_ir, b_act, b_nact, b_busy, b_ovr, b_tmo} !== 49'h0) begin
            failures++;
            $display("FAIL reset_b got=%h exp=0", {b_jdo, b_cmd_ir, b_act, b_nact, b_busy, b_ovr, b_tmo});
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=0", a_busy);
        end
    endtask

    task automatic test_action();
        run_cmd(38'h20_0000_0055, 2'd2, 1'b0);
        tick();
        checks++;
        if (a_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_until_ack got=%b exp=1", a_busy);
        end
        ack_once();
        checks++;
        if (a_jdo !== 38'h20_0000_0055) begin
            failures++;
            $display("FAIL jdo_action got=%h exp=%h", a_jdo, 38'h20_0000_0055);
        end
    endtask

    task automatic test_no_action();
        run_cmd(38'h15_A5A5_A5A5, 2'd1, 1'b0);
        ack_once();
        // Simultaneous IR and DR update while idle still captures.
        run_cmd(38'h00_1234_5678, 2'd3, 1'b1);
        ack_once();
    endtask

    task automatic test_timeout();
        run_cmd(38'h2A_0000_0001, 2'd0, 1'b0);
        repeat (7) tick();
        checks++;
        if ({a_tmo, a_busy} !== 2'b01) begin
            failures++;
            $display("FAIL timeout_early got=%b exp=01", {a_tmo, a_busy});
        end
        tick();
        checks++;
        if ({a_tmo, a_busy} !== 2'b10) begin
            failures++;
            $display("FAIL timeout_fire got=%b exp=10", {a_tmo, a_busy});
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (a_tmo !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got=%b exp=0", a_tmo);
        end
    endtask

    task automatic test_overrun();
        run_cmd(38'h3F_0000_1234, 2'd3, 1'b0);
        sr_in = 38'h0A_BCDE_F012;
        ir_in = 2'd0;
        udr_toggle = ~udr_toggle;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({a_act, a_nact} !== 8'h00) begin
                failures++;
                $display("FAIL overrun_pulse edge=%0d got=%h exp=00", k, {a_act, a_nact});
            end
            if (k == 2) begin
                checks++;
                if (a_ovr !== 1'b0) begin
                    failures++;
                    $display("FAIL overrun_early got=%b exp=0", a_ovr);
                end
                err_clr = 1'b1;
            end
            if (k == 3) err_clr = 1'b0;
        end
        checks++;
        if ({a_ovr, a_busy} !== 2'b11) begin
            failures++;
            $display("FAIL overrun_set got=%b exp=11", {a_ovr, a_busy});
        end
        checks++;
        if (a_jdo !== 38'h3F_0000_1234) begin
            failures++;
            $display("FAIL overrun_jdo got=%h exp=%h", a_jdo, 38'h3F_0000_1234);
        end
        ack_once();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++;
        if (a_ovr !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear got=%b exp=0", a_ovr);
        end
    endtask

    task automatic test_uir_abort();
        run_cmd(38'h00_0000_00FF, 2'd0, 1'b0);
        uir_toggle = ~uir_toggle;
        repeat (3) tick();
        checks++;
        if (a_busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_early got=%b exp=1", a_busy);
        end
        tick();
        checks++;
        if ({a_busy, a_ovr, a_tmo} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=000", {a_busy, a_ovr, a_tmo});
        end
        // Ack arrives in the very cycle the timeout would fire.
        run_cmd(38'h20_0000_0ACE, 2'd1, 1'b0);
        repeat (7) tick();
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        checks++;
        if ({a_busy, a_tmo} !== 2'b00) begin
            failures++;
            $display("FAIL ack_vs_timeout got=%b exp=00", {a_busy, a_tmo});
        end
    endtask

    task automatic test_reset_mid_issue();
        sr_in = 38'h20_1111_2222;
        ir_in = 2'd0;
        udr_toggle = ~udr_toggle;
        repeat (5) tick();
        checks++;
        if ({a_act, a_nact} !== 8'h10) begin
            failures++;
            $display("FAIL mid_issue_pulse got=%h exp=10", {a_act, a_nact});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({a_jdo, a_cmd_ir, a_act, a_nact, a_busy, a_ovr, a_tmo} !== 49'h0) begin
            failures++;
            $display("FAIL mid_reset_a got=%h exp=0", {a_jdo, a_cmd_ir, a_act, a_nact, a_busy, a_ovr, a_tmo});
        end
        checks++;
        if ({b_jdo, b_act, b_nact, b_busy} !== 47'h0) begin
            failures++;
            $display("FAIL mid_reset_b got=%h exp=0", {b_jdo, b_act, b_nact, b_busy});
        end
        udr_toggle = 1'b0;
        uir_toggle = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        checks++;
        if ({a_busy, a_jdo} !== 39'h0) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0", {a_busy, a_jdo});
        end
    endtask

    initial begin
        test_reset();
        test_action();
        test_no_action();
        test_timeout();
        test_overrun();
        test_uir_abort();
        test_reset_mid_issue();
        run_cmd(38'h1F_FFFF_FFFF, 2'd2, 1'b0);
        ack_once();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
